mux_pipe_reg: RTL and testbench
===============================

Name: mux_pipe_reg

Overview:
- Parametrised N-input datapath selector fused with a ready/valid pipeline stage and a one-entry skid buffer.
- Next-generation replacement for the plain 2:1 combinational selector. Used at pipeline-stage boundaries such as forwarding-source selection into EX and PC-source selection into IF.
- The selected word is registered, so downstream stalls never combinationally reach the upstream stage.
- A flush input supports branch/exception squash.

Parameters:
- WIDTH, 32, data word width in bits.
- NUM_IN, 4, number of selectable inputs (2..16).
- SEL_W, 2, select width; must satisfy 2**SEL_W >= NUM_IN.
- RESET_VAL, 0, value of out_data after reset.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- sel  input  SEL_W  binary index of the input to capture.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  1  upstream offers data this cycle.
- in_ready  output  1  stage can accept this cycle.
- flush  input  1  discard all held and incoming data.
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts this cycle.
- occ  output  2  entries held (0, 1 or 2).
- sel_err  output  1  one-cycle pulse: an accepted beat had sel >= NUM_IN.

Behaviour:
- Accept = in_valid & in_ready.
- Pop = out_valid & out_ready.
- Captured word is in_data slice [sel]. If sel >= NUM_IN, input 0 is captured and sel_err pulses high in the following cycle.
- Latency is 1 cycle: a word accepted at edge N is on out_data with out_valid=1 after edge N.
- Storage is a main register (drives out_data) and a skid register.
- in_ready = (state != SKID) & ~rst. It is derived only from registered state; it never depends on out_ready.
- States:
  - EMPTY (occ=0)
  - FULL (occ=1)
  - SKID (occ=2)
- EMPTY:
  - accept -> FULL; main <= selected word.
- FULL:
  - accept & ~pop -> SKID; skid <= selected word.
  - pop & ~accept -> EMPTY.
  - accept & pop -> FULL; main <= selected word.
  - neither -> FULL, hold.
- SKID:
  - pop -> FULL; main <= skid.
  - otherwise hold.
  - No accept is possible, since in_ready=0.
- out_valid = (state != EMPTY).
- out_data holds its last value in EMPTY; it does not return to RESET_VAL.
- Data ordering is strict FIFO; no beat is lost or duplicated except by flush.
- flush, which has priority over all other events:
  - Next state is EMPTY; out_valid=0 after the edge.
  - A beat accepted in the same cycle is dropped; its handshake still counts as complete upstream.
  - A pop in the same cycle still completes downstream.
  - sel_err is suppressed for a dropped beat.
  - out_data holds its value.
- rst (synchronous):
  - Next state is EMPTY; out_data=RESET_VAL, out_valid=0, occ=0, sel_err=0.
  - in_ready=0 while rst is high.
  - rst asserted mid-operation discards both entries; rst has priority over flush.
- Throughput is one beat per cycle when out_ready stays high.
- Inputs are not required to be stable while not accepted.

Decomposition:
- Shared package `mux_pkg` holds:
  - state encoding constants ST_EMPTY=2'd0, ST_FULL=2'd1, ST_SKID=2'd2;
  - a function computing the minimum SEL_W from NUM_IN.
- One natural sub-module: `mux_n`, a purely combinational N-way parametrised selector with the out-of-range fallback and an out-of-range flag. Used as the selection front-end; it also replaces existing 2:1 instances over time.
- The state machine and registers live in the top module.

Test Plan:
- Basic select: NUM_IN=4, WIDTH=32, inputs 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, in_valid=1, out_ready=1 for one cycle -> next cycle out_data=0x33333333, out_valid=1, occ=1, sel_err=0.
- Skid fill: out_ready=0, three consecutive in_valid beats with sel=0,1,3 -> first two accepted; in_ready=0 from the third cycle; occ=2. Then out_ready=1 -> outputs 0x11111111, 0x22222222, then 0x44444444 after in_ready returns.
- Streaming: in_valid=1 and out_ready=1 for 8 cycles, sel cycling 0..3 -> 8 outputs in order, one per cycle; occ stays 1; in_ready never drops.
- Bad select: NUM_IN=3, SEL_W=2, sel=3 accepted -> out_data=input 0 value; sel_err=1 for exactly one cycle. Repeating the beat with flush=1 -> sel_err stays 0.
- Flush: occ=2, flush=1 with in_valid=1 -> next cycle occ=0, out_valid=0, in_ready=1, out_data unchanged; the new beat never appears.
- Reset mid-operation: occ=2, rst=1 for one cycle -> occ=0, out_valid=0, out_data=RESET_VAL; in_ready=0 during the rst cycle and 1 after it.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the selector pipeline family: state encoding
// (doubles as occupancy count) and select-width sizing helper.
package mux_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_FULL  = 2'd1,
      ST_SKID  = 2'd2
   } state_t;

   // Smallest select width that can address n inputs (at least 1 bit).
   function automatic int min_sel_w(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/mux_n.sv
// Combinational N-way word selector; out-of-range selects fall back to
// input 0 and raise oor.
module mux_n
   import mux_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int NUM_IN = 4,
   parameter int SEL_W  = min_sel_w(NUM_IN)
) (
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   output logic [WIDTH-1:0]        out_data,
   output logic                    oor
);

   always_comb begin
      out_data = in_data[0 +: WIDTH];
      oor      = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (sel == SEL_W'(k)) begin
            out_data = in_data[k*WIDTH +: WIDTH];
            oor      = 1'b0;
         end
      end
   end

endmodule

// File: rtl/mux_pipe_reg.sv
// N-input selector feeding a registered ready/valid stage with a one-entry
// skid buffer; in_ready depends only on registered state.
module mux_pipe_reg
   import mux_pkg::*;
#(
   parameter int               WIDTH     = 32,
   parameter int               NUM_IN    = 4,
   parameter int               SEL_W     = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [SEL_W-1:0]        sel,
   input  logic [NUM_IN*WIDTH-1:0] in_data,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    flush,
   output logic [WIDTH-1:0]        out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [1:0]              occ,
   output logic                    sel_err
);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             sel_err_q, sel_err_d;
   logic [WIDTH-1:0] sel_word;
   logic             sel_oor;
   logic             accept, pop;

   mux_n #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) u_sel (
      .sel      (sel),
      .in_data  (in_data),
      .out_data (sel_word),
      .oor      (sel_oor)
   );

   assign in_ready  = (state_q != ST_SKID) & ~rst;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign occ       = 2'(state_q);
   assign sel_err   = sel_err_q;

   always_comb begin
      accept    = in_valid & in_ready;
      pop       = out_valid & out_ready;
      state_d   = state_q;
      main_d    = main_q;
      skid_d    = skid_q;
      sel_err_d = accept & sel_oor & ~flush;

      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_FULL;
               main_d  = sel_word;
            end
         end
         ST_FULL: begin
            if (accept && !pop) begin
               state_d = ST_SKID;
               skid_d  = sel_word;
            end else if (pop && !accept) begin
               state_d = ST_EMPTY;
            end else if (accept && pop) begin
               main_d = sel_word;
            end
         end
         ST_SKID: begin
            if (pop) begin
               state_d = ST_FULL;
               main_d  = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase

      // Squash overrides everything; the visible word is left untouched.
      if (flush) begin
         state_d = ST_EMPTY;
         main_d  = main_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_EMPTY;
         main_q    <= RESET_VAL;
         sel_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         sel_err_q <= sel_err_d;
      end
   end

   always_ff @(posedge clk) begin
      skid_q <= skid_d;
   end

endmodule

// File: tb/tb_mux_pipe_reg.sv
// Directed bench for mux_pipe_reg: a 4-input instance for the handshake
// paths and a 3-input instance for out-of-range selects.
module tb_mux_pipe_reg;

   localparam logic [31:0] V0 = 32'h1111_1111;
   localparam logic [31:0] V1 = 32'h2222_2222;
   localparam logic [31:0] V2 = 32'h3333_3333;
   localparam logic [31:0] V3 = 32'h4444_4444;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] in_data;

   logic [1:0]  sel, occ;
   logic        in_valid, in_ready, flush, out_valid, out_ready, sel_err;
   logic [31:0] out_data;

   logic [1:0]  sel3, occ3;
   logic        in_valid3, in_ready3, flush3, out_valid3, out_ready3, sel_err3;
   logic [31:0] out_data3;

   int n_vec  = 0;
   int n_miss = 0;

   always #5 clk = ~clk;

   mux_pipe_reg #(.WIDTH(32), .NUM_IN(4), .SEL_W(2), .RESET_VAL(32'h0)) dut (
      .clk(clk), .rst(rst), .sel(sel), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .occ(occ), .sel_err(sel_err)
   );

   mux_pipe_reg #(.WIDTH(32), .NUM_IN(3), .SEL_W(2), .RESET_VAL(32'h0)) dut3 (
      .clk(clk), .rst(rst), .sel(sel3), .in_data(in_data[95:0]),
      .in_valid(in_valid3), .in_ready(in_ready3), .flush(flush3),
      .out_data(out_data3), .out_valid(out_valid3), .out_ready(out_ready3),
      .occ(occ3), .sel_err(sel_err3)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_data = {V3, V2, V1, V0};
      sel = 2'd0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      sel3 = 2'd0; in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b0;
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b0;
      tick();
      check("rst_out_data", out_data, 32'h0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_occ", 32'(occ), 32'd0);
      check("rst_sel_err", 32'(sel_err), 32'd0);
      check("rst_in_ready_after", 32'(in_ready), 32'd1);

      // basic select
      sel = 2'd2; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      check("basic_data", out_data, V2);
      check("basic_valid", 32'(out_valid), 32'd1);
      check("basic_occ", 32'(occ), 32'd1);
      check("basic_sel_err", 32'(sel_err), 32'd0);
      tick();
      check("drain_occ", 32'(occ), 32'd0);
      check("empty_hold_data", out_data, V2);

      // skid fill with downstream stalled
      out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
      tick();
      check("skid1_occ", 32'(occ), 32'd1);
      check("skid1_data", out_data, V0);
      check("skid1_in_ready", 32'(in_ready), 32'd1);
      sel = 2'd1;
      tick();
      check("skid2_occ", 32'(occ), 32'd2);
      check("skid2_in_ready", 32'(in_ready), 32'd0);
      sel = 2'd3;
      tick();
      check("skid3_occ", 32'(occ), 32'd2);
      check("skid3_data", out_data, V0);
      out_ready = 1'b1;
      tick();
      check("unskid_data", out_data, V1);
      check("unskid_occ", 32'(occ), 32'd1);
      check("unskid_in_ready", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      check("third_data", out_data, V3);
      check("third_occ", 32'(occ), 32'd1);
      tick();
      check("skid_drained", 32'(occ), 32'd0);

      // streaming, one beat per cycle
      in_valid = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [31:0] exp_w;
         sel = 2'(i % 4);
         exp_w = 32'(i % 4 + 1) * 32'h1111_1111;
         tick();
         check($sformatf("stream%0d_data", i), out_data, exp_w);
         check($sformatf("stream%0d_occ", i), 32'(occ), 32'd1);
         check($sformatf("stream%0d_rdy", i), 32'(in_ready), 32'd1);
      end
      in_valid = 1'b0;
      tick();
      check("stream_drained", 32'(occ), 32'd0);

      // flush with both entries held
      out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
      tick();
      sel = 2'd1;
      tick();
      check("preflush_occ", 32'(occ), 32'd2);
      flush = 1'b1; sel = 2'd2;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush_occ", 32'(occ), 32'd0);
      check("flush_valid", 32'(out_valid), 32'd0);
      check("flush_in_ready", 32'(in_ready), 32'd1);
      check("flush_data_hold", out_data, V0);

      // flush drops a beat accepted in the same cycle
      in_valid = 1'b1; sel = 2'd3;
      tick();
      check("pre_flush2_data", out_data, V3);
      flush = 1'b1; sel = 2'd2;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      check("flush2_occ", 32'(occ), 32'd0);
      check("flush2_data", out_data, V3);
      tick();
      check("flush2_no_beat", 32'(out_valid), 32'd0);
      check("flush2_data_later", out_data, V3);

      // out-of-range select on the 3-input instance
      sel3 = 2'd3; in_valid3 = 1'b1; out_ready3 = 1'b1;
      tick();
      in_valid3 = 1'b0;
      check("bad_sel_data", out_data3, V0);
      check("bad_sel_err", 32'(sel_err3), 32'd1);
      tick();
      check("bad_sel_err_pulse", 32'(sel_err3), 32'd0);
      sel3 = 2'd2; in_valid3 = 1'b1;
      tick();
      in_valid3 = 1'b0;
      check("good_sel3_data", out_data3, V2);
      check("good_sel3_err", 32'(sel_err3), 32'd0);
      sel3 = 2'd3; in_valid3 = 1'b1; flush3 = 1'b1;
      tick();
      in_valid3 = 1'b0; flush3 = 1'b0;
      check("flush_sel_err", 32'(sel_err3), 32'd0);
      check("flush_sel_occ", 32'(occ3), 32'd0);
      tick();
      check("flush_sel_err_late", 32'(sel_err3), 32'd0);

      // reset in the middle of a held skid
      out_ready = 1'b0; in_valid = 1'b1; sel = 2'd0;
      tick();
      sel = 2'd1;
      tick();
      in_valid = 1'b0;
      check("prerst_occ", 32'(occ), 32'd2);
      rst = 1'b1;
      #1;
      check("midrst_in_ready", 32'(in_ready), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("postrst_occ", 32'(occ), 32'd0);
      check("postrst_valid", 32'(out_valid), 32'd0);
      check("postrst_data", out_data, 32'h0);
      check("postrst_in_ready", 32'(in_ready), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
